// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: the USB packet word type,
// the header field positions and a helper that builds a data-packet header.
//
// Packet word layout:
//   [31:29] peripheral address
//   [28]    packet type (0 = data)
//   [27:26] reserved, always 0
//   [25:24] byte count, 1..3
//   [23:0]  payload, byte0 in [7:0], byte1 in [15:8], byte2 in [23:16]
package uart_pkg;

  localparam int usb_packet_width = 32;

  localparam int HDR_ADDR_MSB = 31;
  localparam int HDR_ADDR_LSB = 29;
  localparam int HDR_TYPE_BIT = 28;
  localparam int HDR_RSVD_MSB = 27;
  localparam int HDR_RSVD_LSB = 26;
  localparam int HDR_CNT_MSB  = 25;
  localparam int HDR_CNT_LSB  = 24;

  typedef logic [usb_packet_width-1:0] usb_packet_t;

  // Header-only word for a data packet; the payload bits are left at zero so
  // the caller can OR the data bytes in.
  function automatic usb_packet_t make_data_header(input logic [2:0] addr,
                                                   input logic [1:0] count);
    usb_packet_t h;
    h = '0;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    h[HDR_TYPE_BIT]              = 1'b0;
    h[HDR_RSVD_MSB:HDR_RSVD_LSB] = 2'b00;
    h[HDR_CNT_MSB:HDR_CNT_LSB]   = count;
    return h;
  endfunction

endpackage

// File: rtl/uart_rx_packer_idle_timer.sv
// idle_timer
// Counts idle clocks while enabled and raises fire once the count reaches
// timeout_cycles-1. The count saturates there, so fire stays high until the
// owner either clears the timer or drops enable.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   clear   - synchronous clear to 0 (has priority over enable)
//   enable  - count while high
//   fire    - timeout reached (combinational from the count)
module idle_timer #(
  parameter int timeout_cycles = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic fire
);

  localparam int cnt_width = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [cnt_width-1:0] last_count = cnt_width'(timeout_cycles - 1);

  logic [cnt_width-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != last_count)) begin
      count_reg <= count_reg + cnt_width'(1);
    end
  end

  assign fire = enable & (count_reg == last_count);

endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer
// Packs received UART bytes into 32-bit USB data packets (up to three bytes
// plus a header) and writes them into the RX FIFO. A partially filled packet
// is flushed after timeout_cycles idle clocks. Bytes that arrive while both
// the accumulator and the pending word are full are dropped and flagged.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   byte_in     - received byte, qualified by byte_valid
//   byte_valid  - one-cycle strobe per received byte
//   rx_data     - packet word to the FIFO (pending register)
//   rx_full     - FIFO full
//   rx_wren     - FIFO write strobe (pending & ~rx_full)
//   overrun     - sticky: at least one byte was dropped
//   overrun_clr - clears overrun (a simultaneous drop wins)
//   busy        - accumulator holds bytes or a packet is pending
module uart_rx_packer #(
  parameter int         usb_packet_width = 32,
  parameter logic [2:0] periph_addr      = 3'd0,
  parameter int         timeout_cycles   = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic [usb_packet_width-1:0] rx_data,
  input  logic                        rx_full,
  output logic                        rx_wren,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic                        busy
);

  import uart_pkg::usb_packet_t;
  import uart_pkg::make_data_header;

  // IDLE: count 0, FILL: count 1..2, HOLD: count 3 waiting for the pending slot.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } pack_state_t;

  pack_state_t state_reg;
  logic [1:0]  count_reg;
  logic [7:0]  slot_reg [3];
  logic        pending_reg;
  usb_packet_t pend_word_reg;
  logic        overrun_reg;

  logic        handoff_ok;
  logic        byte_accept;
  logic        byte_drop;
  logic        timer_clear;
  logic        timer_fire;
  logic [7:0]  acc_byte [3];
  usb_packet_t acc_word;
  usb_packet_t complete_word;

  assign rx_wren = pending_reg & ~rx_full;

  // The pending slot is free for a new word if it is empty or is being
  // drained by the FIFO write happening this very cycle.
  assign handoff_ok = ~pending_reg | rx_wren;

  // A byte in HOLD is only taken if the held packet leaves this cycle.
  assign byte_accept = byte_valid & ((state_reg != ST_HOLD) | handoff_ok);
  assign byte_drop   = byte_valid & (state_reg == ST_HOLD) & ~handoff_ok;

  // Keep the timer parked at 0 outside FILL so every partial packet gets a
  // full timeout window starting from its most recent byte.
  assign timer_clear = byte_accept | (state_reg != ST_FILL);

  idle_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(state_reg == ST_FILL),
    .fire  (timer_fire)
  );

  // Slots at or above the current count may hold stale bytes from an earlier
  // packet; mask them so unused payload bytes go out as zero.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_acc_mask
      assign acc_byte[gi] = (count_reg > 2'(gi)) ? slot_reg[gi] : 8'h00;
    end
  endgenerate

  // Word built from the accumulator as it stands (partial flush or HOLD).
  assign acc_word = make_data_header(periph_addr, count_reg) |
                    {8'h00, acc_byte[2], acc_byte[1], acc_byte[0]};

  // Word built when the third byte arrives: that byte goes straight into the
  // packet on the same edge instead of passing through slot 2.
  assign complete_word = make_data_header(periph_addr, 2'd3) |
                         {8'h00, byte_in, slot_reg[1], slot_reg[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 2'd0;
      pending_reg   <= 1'b0;
      pend_word_reg <= '0;
      overrun_reg   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        slot_reg[i] <= 8'h00;
      end
    end else begin
      // Drain; a handoff below on the same edge re-fills the pending slot.
      if (rx_wren) begin
        pending_reg <= 1'b0;
      end

      if (byte_drop) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (byte_valid) begin
            slot_reg[0] <= byte_in;
            count_reg   <= 2'd1;
            state_reg   <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (byte_valid) begin
            if (count_reg == 2'd2) begin
              if (handoff_ok) begin
                pend_word_reg <= complete_word;
                pending_reg   <= 1'b1;
                count_reg     <= 2'd0;
                state_reg     <= ST_IDLE;
              end else begin
                slot_reg[2] <= byte_in;
                count_reg   <= 2'd3;
                state_reg   <= ST_HOLD;
              end
            end else begin
              slot_reg[count_reg] <= byte_in;
              count_reg           <= count_reg + 2'd1;
            end
          end else if (timer_fire && handoff_ok) begin
            pend_word_reg <= acc_word;
            pending_reg   <= 1'b1;
            count_reg     <= 2'd0;
            state_reg     <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (handoff_ok) begin
            pend_word_reg <= acc_word;
            pending_reg   <= 1'b1;
            if (byte_valid) begin
              // Byte arriving as the held packet leaves starts the next one.
              slot_reg[0] <= byte_in;
              count_reg   <= 2'd1;
              state_reg   <= ST_FILL;
            end else begin
              count_reg <= 2'd0;
              state_reg <= ST_IDLE;
            end
          end
        end

        default: begin
          count_reg <= 2'd0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data = pend_word_reg;
  assign overrun = overrun_reg;
  assign busy    = (count_reg != 2'd0) | pending_reg;

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer
// Two packers share one stimulus stream: dut_a uses address 0 and dut_b uses
// address 5, both with a 10-cycle idle timeout. Expected FIFO writes (word in
// address-0 form plus the cycle it must appear) are queued by the stimulus;
// one monitor per instance pops and compares on every rx_wren.
module tb_uart_rx_packer;

  localparam int T = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        rx_full = 1'b0;
  logic        overrun_clr = 1'b0;

  logic [31:0] rx_data_a, rx_data_b;
  logic        rx_wren_a, rx_wren_b;
  logic        overrun_a, overrun_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          at_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  uart_rx_packer #(
    .usb_packet_width(32),
    .periph_addr     (3'd0),
    .timeout_cycles  (T)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .rx_data    (rx_data_a),
    .rx_full    (rx_full),
    .rx_wren    (rx_wren_a),
    .overrun    (overrun_a),
    .overrun_clr(overrun_clr),
    .busy       (busy_a)
  );

  uart_rx_packer #(
    .usb_packet_width(32),
    .periph_addr     (3'd5),
    .timeout_cycles  (T)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .rx_data    (rx_data_b),
    .rx_full    (rx_full),
    .rx_wren    (rx_wren_b),
    .overrun    (overrun_b),
    .overrun_clr(overrun_clr),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  // After rising edge k, cyc == k; a write seen in the cycle following edge k
  // is therefore stamped with k.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && rx_wren_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL write_a unexpected rx_data=%h cyc=%0d", rx_data_a, cyc);
      end else begin
        e_a = q_a.pop_front();
        if (rx_data_a !== e_a.data || cyc != e_a.at_cyc) begin
          errors++;
          $display("FAIL write_a got %h at cyc %0d expected %h at cyc %0d",
                   rx_data_a, cyc, e_a.data, e_a.at_cyc);
        end else begin
          $display("write_a rx_data=%h cyc=%0d", rx_data_a, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rx_wren_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL write_b unexpected rx_data=%h cyc=%0d", rx_data_b, cyc);
      end else begin
        e_b = q_b.pop_front();
        if (rx_data_b !== e_b.data || cyc != e_b.at_cyc) begin
          errors++;
          $display("FAIL write_b got %h at cyc %0d expected %h at cyc %0d",
                   rx_data_b, cyc, e_b.data, e_b.at_cyc);
        end else begin
          $display("write_b rx_data=%h cyc=%0d", rx_data_b, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Queue one expected write for both instances; dut_b carries address 5.
  task automatic expect_write(input logic [31:0] data, input int at_cyc);
    exp_t e;
    e.data   = data;
    e.at_cyc = at_cyc;
    q_a.push_back(e);
    e.data   = data | 32'hA000_0000;
    q_b.push_back(e);
  endtask

  // Called and returns at 1 time unit after a rising edge; edge_n is the
  // edge on which the byte is sampled.
  task automatic send_byte(input logic [7:0] b, output int edge_n);
    byte_in    = b;
    byte_valid = 1'b1;
    edge_n     = cyc + 1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e;
    int p;

    #2 rst = 1'b0;
    idle(3);
    check("reset_wren", {31'd0, rx_wren_a}, 32'd0);
    check("reset_data", rx_data_a, 32'd0);
    check("reset_overrun", {31'd0, overrun_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Three back-to-back bytes: write one cycle after the third byte.
    send_byte(8'h11, e);
    send_byte(8'h22, e);
    send_byte(8'h33, e);
    expect_write(32'h0333_2211, e);
    check("t1_busy", {31'd0, busy_a}, 32'd1);
    idle(15);

    // Lone byte flushed by the timeout.
    send_byte(8'hA5, e);
    expect_write(32'h0100_00A5, e + T);
    check("t2_busy_fill", {31'd0, busy_a}, 32'd1);
    idle(25);
    check("t2_busy_after", {31'd0, busy_a}, 32'd0);

    // Two-byte partial packet (address 5 seen on dut_b).
    send_byte(8'hDE, e);
    send_byte(8'hAD, e);
    expect_write(32'h0200_ADDE, e + T);
    idle(15);

    // Six back-to-back bytes give two full packets.
    send_byte(8'hC1, e);
    send_byte(8'hC2, e);
    send_byte(8'hC3, e);
    expect_write(32'h03C3_C2C1, e);
    send_byte(8'hC4, e);
    send_byte(8'hC5, e);
    send_byte(8'hC6, e);
    expect_write(32'h03C6_C5C4, e);
    idle(15);

    // Backpressure: fill pending and HOLD, drop the seventh byte.
    rx_full = 1'b1;
    send_byte(8'h01, e);
    send_byte(8'h02, e);
    send_byte(8'h03, e);
    send_byte(8'h04, e);
    send_byte(8'h05, e);
    send_byte(8'h06, e);
    check("t3_overrun_before", {31'd0, overrun_a}, 32'd0);
    send_byte(8'h07, e);
    check("t3_overrun_a", {31'd0, overrun_a}, 32'd1);
    check("t3_overrun_b", {31'd0, overrun_b}, 32'd1);
    idle(2);
    check("t3_busy_hold", {31'd0, busy_a}, 32'd1);
    rx_full = 1'b0;
    p = cyc;
    expect_write(32'h0303_0201, p);
    expect_write(32'h0306_0504, p + 1);
    idle(15);
    check("t3_busy_after", {31'd0, busy_a}, 32'd0);
    check("t3_overrun_sticky", {31'd0, overrun_a}, 32'd1);

    // Reset mid-packet discards the two buffered bytes and the flag.
    send_byte(8'h5A, e);
    send_byte(8'h5B, e);
    rst = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy_a}, 32'd0);
    check("t5_rst_overrun", {31'd0, overrun_a}, 32'd0);
    check("t5_rst_wren", {31'd0, rx_wren_a}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send_byte(8'h77, e);
    send_byte(8'h88, e);
    send_byte(8'h99, e);
    expect_write(32'h0399_8877, e);
    idle(15);
    check("t5_overrun", {31'd0, overrun_a}, 32'd0);

    // Drop coinciding with a clear keeps the flag; a clear alone drops it.
    rx_full = 1'b1;
    send_byte(8'hA1, e);
    send_byte(8'hA2, e);
    send_byte(8'hA3, e);
    send_byte(8'hA4, e);
    send_byte(8'hA5, e);
    send_byte(8'hA6, e);
    send_byte(8'hA7, e);
    check("t6_overrun_set", {31'd0, overrun_a}, 32'd1);
    overrun_clr = 1'b1;
    send_byte(8'hA8, e);
    overrun_clr = 1'b0;
    check("t6_set_wins", {31'd0, overrun_a}, 32'd1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("t6_cleared", {31'd0, overrun_a}, 32'd0);
    check("t6_cleared_b", {31'd0, overrun_b}, 32'd0);
    rx_full = 1'b0;
    p = cyc;
    expect_write(32'h03A3_A2A1, p);
    expect_write(32'h03A6_A5A4, p + 1);
    idle(20);

    check("queue_a_drained", q_a.size(), 32'd0);
    check("queue_b_drained", q_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
